regfile_2r1w: RTL and testbench



---
 rtl/regfile_2r1w.sv | 72 +++++++
 tb/tb_regfile_2r1w.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read / 1-write register file with registered read data.
// Register 0 is hardwired to zero (RISC-V x0). Reads have one cycle of latency.
// Optional macro REGFILE_BYPASS_EN: when defined, a read and a write to the same
// nonzero index on the same edge returns the new data (write-first). When it is
// undefined, the read returns the old data (read-first).
module regfile_2r1w #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [XLEN-1:0]            rdata1_q, rdata1_d;
    logic [XLEN-1:0]            rdata2_q, rdata2_d;

    // Next storage state: apply the write unless it targets x0.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Next read data for both ports; x0 always reads zero, collisions optionally bypass.
    always_comb begin
        rdata1_d = '0;
        rdata2_d = '0;
        if (raddr1 != '0) begin
            rdata1_d = regs_q[raddr1];
`ifdef REGFILE_BYPASS_EN
            if (we && (waddr == raddr1)) begin
                rdata1_d = wdata;
            end
`endif
        end
        if (raddr2 != '0) begin
            rdata2_d = regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
            if (we && (waddr == raddr2)) begin
                rdata2_d = wdata;
            end
`endif
        end
    end

    // State update; reset clears storage and outputs and drops any write in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            regs_q   <= regs_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Testbench for regfile_2r1w: a reference model predicts read data when stimulus
// is driven (on negedge); expectations are queued and compared after the edge.
module tb_regfile_2r1w;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            we = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [XLEN-1:0] wdata = '0;
    logic [AW-1:0]   raddr1 = '0;
    logic [AW-1:0]   raddr2 = '0;
    logic [XLEN-1:0] rdata1, rdata2;

    logic [XLEN-1:0] model [NREGS];
    logic [XLEN-1:0] exp1_q [$];
    logic [XLEN-1:0] exp2_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Model of one read port at the edge, given the pre-edge storage.
    function automatic logic [XLEN-1:0] model_rd(input logic w, input logic [AW-1:0] wa,
                                                 input logic [XLEN-1:0] wd, input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == '0) return '0;
        v = model[a];
`ifdef REGFILE_BYPASS_EN
        if (w && wa == a) v = wd;
`endif
        return v;
    endfunction

    // Drive one cycle on negedge, push the expected read data, update the model, wait for the edge.
    task automatic step(input logic r, input logic w, input logic [AW-1:0] wa,
                        input logic [XLEN-1:0] wd, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
        if (r) begin
            exp1_q.push_back('0);
            exp2_q.push_back('0);
            for (int i = 0; i < NREGS; i++) model[i] = '0;
        end else begin
            exp1_q.push_back(model_rd(w, wa, wd, a1));
            exp2_q.push_back(model_rd(w, wa, wd, a2));
            if (w && wa != '0) model[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] e1, e2;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, AW'(5), 32'hDEADBEEF, AW'(5), AW'(5));
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            n_checks++;
            if (rdata1 !== 32'h0 || e1 !== 32'h0) $display("FAIL reset_hold rdata1=%h expected 0", rdata1);
            else n_pass++;
        end
        step(1'b0, 1'b0, '0, '0, AW'(5), AW'(5));
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== 32'h0) $display("FAIL reset_discard_write rdata1=%h expected 0", rdata1);
        else n_pass++;
        for (int i = 0; i < NREGS; i++) begin
            step(1'b0, 1'b0, '0, '0, AW'(i), AW'(NREGS - 1 - i));
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            n_checks++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
                $display("FAIL reset_all_zero idx=%0d rdata1=%h rdata2=%h expected 0", i, rdata1, rdata2);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [XLEN-1:0] e1, e2;
        step(1'b0, 1'b1, AW'(7), 32'h1234_5678, '0, '0);
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        step(1'b0, 1'b0, '0, '0, AW'(7), AW'(7));
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h1234_5678 || e1 !== e2)
            $display("FAIL basic_rw rdata1=%h rdata2=%h expected 12345678", rdata1, rdata2);
        else n_pass++;
    endtask

    task automatic test_x0();
        logic [XLEN-1:0] e1, e2;
        step(1'b0, 1'b1, '0, 32'hFFFF_FFFF, '0, AW'(7));
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== 32'h0) $display("FAIL x0_same_cycle rdata1=%h expected 0", rdata1);
        else n_pass++;
        step(1'b0, 1'b0, '0, '0, '0, '0);
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
            $display("FAIL x0_after_write rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [XLEN-1:0] e1, e2, want;
`ifdef REGFILE_BYPASS_EN
        want = 32'hB;
`else
        want = 32'hA;
`endif
        step(1'b0, 1'b1, AW'(3), 32'hA, '0, '0);
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        step(1'b0, 1'b1, AW'(3), 32'hB, AW'(3), AW'(3));
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== want || rdata2 !== e2)
            $display("FAIL collision rdata1=%h rdata2=%h expected %h", rdata1, rdata2, want);
        else n_pass++;
        step(1'b0, 1'b0, '0, '0, AW'(3), '0);
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== 32'hB || rdata2 !== 32'h0)
            $display("FAIL collision_next rdata1=%h rdata2=%h expected 0000000b/0", rdata1, rdata2);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [XLEN-1:0] e1, e2;
        int bad = 0;
        for (int c = 0; c < 10000; c++) begin
            step(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)), $urandom(),
                 AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)));
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            n_checks++;
            if (rdata1 !== e1) begin
                if (bad < 10) $display("FAIL random_p1 cycle=%0d rdata1=%h expected %h", c, rdata1, e1);
                bad++;
            end else n_pass++;
            n_checks++;
            if (rdata2 !== e2) begin
                if (bad < 10) $display("FAIL random_p2 cycle=%0d rdata2=%h expected %h", c, rdata2, e2);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_midreset();
        logic [XLEN-1:0] e1, e2;
        for (int i = 1; i < NREGS; i++) begin
            step(1'b0, 1'b1, AW'(i), 32'hC0DE_0000 | i, '0, '0);
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        end
        step(1'b0, 1'b0, '0, '0, AW'(9), AW'(NREGS - 1));
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== 32'hC0DE_0009 || rdata2 !== (32'hC0DE_0000 | (NREGS - 1)))
            $display("FAIL fill_readback rdata1=%h rdata2=%h expected %h/%h", rdata1, rdata2,
                     32'hC0DE_0009, 32'hC0DE_0000 | (NREGS - 1));
        else n_pass++;
        step(1'b1, 1'b1, AW'(4), 32'h5555_5555, AW'(9), AW'(4));
        e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
        n_checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
            $display("FAIL midreset_edge rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
        else n_pass++;
        for (int i = 0; i < NREGS; i++) begin
            step(1'b0, 1'b0, '0, '0, AW'(i), AW'(i));
            e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front();
            n_checks++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
                $display("FAIL midreset_clear idx=%0d rdata1=%h rdata2=%h expected 0", i, rdata1, rdata2);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        test_reset();
        test_basic();
        test_x0();
        test_collision();
        test_random();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
